// File: rtl/quadra_pkg.sv
// Shared widths, types and loader states for the programmable coefficient table.
// The default widths match the quadratic interpolator datapath.
// coef_t packs {a,b,c} with a in the MSBs, which is the loader beat layout.
package quadra_pkg;

  localparam int IDX_W_DEF = 7;
  localparam int A_W_DEF   = 12;
  localparam int B_W_DEF   = 20;
  localparam int C_W_DEF   = 28;
  localparam int COEF_W    = A_W_DEF + B_W_DEF + C_W_DEF;

  typedef logic [IDX_W_DEF-1:0] x1_t;
  typedef logic [A_W_DEF-1:0]   a_t;
  typedef logic [B_W_DEF-1:0]   b_t;
  typedef logic [C_W_DEF-1:0]   c_t;

  typedef struct packed {
    a_t a;
    b_t b;
    c_t c;
  } coef_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2,
    SWAP = 2'd3
  } ld_state_e;

  // Build a packed coefficient word from its three fields.
  function automatic coef_t make_coef(input a_t a, input b_t b, input c_t c);
    coef_t r;
    r.a = a;
    r.b = b;
    r.c = c;
    return r;
  endfunction

endpackage

// File: rtl/quadra_coef_bank.sv
// One coefficient bank: a single write port and a registered read port.
// Read data appears one cycle after the address; contents are never reset.
// A same-cycle write and read of one address returns the old word.
module quadra_coef_bank
  import quadra_pkg::*;
#(
  parameter int AW = IDX_W_DEF,
  parameter int DW = COEF_W
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Write port: loader beats land here when this bank is the shadow.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, read-before-write on an address collision.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/quadra_coef_table.sv
// Double-buffered a/b/c coefficient store: loader fills the shadow bank, commit swaps.
// Reads have a fixed 2-cycle latency, one per cycle, with no read backpressure.
// The loader is stalled (ld_ready_o=0) while the shadow bank is full or swapping.
module quadra_coef_table
  import quadra_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int C_W   = C_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_valid_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic                 rd_valid_o,
  output logic [A_W-1:0]       a_o,
  output logic [B_W-1:0]       b_o,
  output logic [C_W-1:0]       c_o,
  input  logic                 ld_valid_i,
  output logic                 ld_ready_o,
  input  logic [A_W+B_W+C_W-1:0] ld_data_i,
  input  logic                 commit_i,
  input  logic                 abort_i,
  output logic                 table_valid_o,
  output logic                 active_bank_o,
  output logic                 ld_err_o
);

  localparam int DW = A_W + B_W + C_W;

  ld_state_e        state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             active_bank_q, table_valid_q, ld_err_q;

  logic             ld_ready, accept, wr_en, swap_en, err_set;

  logic             rd_vld1_q, rd_vld2_q;
  logic [IDX_W-1:0] rd_idx1_q;
  logic             rd_bank1_q, rd_bank2_q;
  logic             rd_tv1_q, rd_tv2_q;

  logic [DW-1:0]    bank0_rdata, bank1_rdata;
  logic [DW-1:0]    rd_sel;
  logic             rd_keep;

  // Loader state and write pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Loader next state: abort beats commit, commit only acts once the shadow is full.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = LOAD;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
        end else if (accept) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (&wr_ptr_q) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (abort_i) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
        end else if (commit_i) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        state_d  = IDLE;
        wr_ptr_d = '0;
      end
      default: begin
        state_d  = IDLE;
        wr_ptr_d = '0;
      end
    endcase
  end

  // Loader outputs: handshake, shadow write enable, swap and error strobes.
  always_comb begin
    ld_ready = 1'b0;
    accept   = 1'b0;
    wr_en    = 1'b0;
    swap_en  = 1'b0;
    err_set  = 1'b0;
    ld_ready = !rst && ((state_q == IDLE) || (state_q == LOAD));
    accept   = ld_valid_i && ld_ready;
    // An aborted beat is handshaken but its data is thrown away.
    wr_en    = accept && !((state_q == LOAD) && abort_i);
    swap_en  = (state_q == SWAP);
    err_set  = commit_i && !abort_i && ((state_q == IDLE) || (state_q == LOAD));
  end

  // Bank select, table-valid flag and sticky early-commit error.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_bank_q <= 1'b0;
      table_valid_q <= 1'b0;
      ld_err_q      <= 1'b0;
    end else begin
      if (swap_en) begin
        active_bank_q <= ~active_bank_q;
        table_valid_q <= 1'b1;
      end
      if (err_set) begin
        ld_err_q <= 1'b1;
      end
    end
  end

  // Read pipeline: bank select and table-valid travel with the index so a swap never tears a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld1_q  <= 1'b0;
      rd_vld2_q  <= 1'b0;
      rd_idx1_q  <= '0;
      rd_bank1_q <= 1'b0;
      rd_bank2_q <= 1'b0;
      rd_tv1_q   <= 1'b0;
      rd_tv2_q   <= 1'b0;
    end else begin
      rd_vld1_q  <= rd_valid_i;
      rd_idx1_q  <= rd_idx_i;
      rd_bank1_q <= active_bank_q;
      rd_tv1_q   <= table_valid_q;
      rd_vld2_q  <= rd_vld1_q;
      rd_bank2_q <= rd_bank1_q;
      rd_tv2_q   <= rd_tv1_q;
    end
  end

  quadra_coef_bank #(.AW(IDX_W), .DW(DW)) u_bank0 (
    .clk     (clk),
    .we_i    (wr_en & active_bank_q),
    .waddr_i (wr_ptr_q),
    .wdata_i (ld_data_i),
    .raddr_i (rd_idx1_q),
    .rdata_o (bank0_rdata)
  );

  quadra_coef_bank #(.AW(IDX_W), .DW(DW)) u_bank1 (
    .clk     (clk),
    .we_i    (wr_en & ~active_bank_q),
    .waddr_i (wr_ptr_q),
    .wdata_i (ld_data_i),
    .raddr_i (rd_idx1_q),
    .rdata_o (bank1_rdata)
  );

  // Output mux; data is zero until a table has been committed and whenever no read is valid.
  always_comb begin
    rd_sel  = rd_bank2_q ? bank1_rdata : bank0_rdata;
    rd_keep = rd_vld2_q && rd_tv2_q;
    a_o     = rd_keep ? rd_sel[DW-1 -: A_W]      : '0;
    b_o     = rd_keep ? rd_sel[B_W+C_W-1 -: B_W] : '0;
    c_o     = rd_keep ? rd_sel[C_W-1:0]          : '0;
  end

  assign rd_valid_o    = rd_vld2_q;
  assign ld_ready_o    = ld_ready;
  assign table_valid_o = table_valid_q;
  assign active_bank_o = active_bank_q;
  assign ld_err_o      = ld_err_q;

endmodule

// File: tb/tb_quadra_coef_table.sv
// Randomized bench for quadra_coef_table with a table-level reference model.
// Reads are scored by a monitor that pops expected words from a queue.
// Loader traffic, commits, aborts and resets are driven from one stimulus thread.
module tb_quadra_coef_table;
  import quadra_pkg::*;

  localparam int DEPTH = 1 << IDX_W_DEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_valid_i = 1'b0;
  x1_t         rd_idx_i = '0;
  logic        rd_valid_o;
  a_t          a_o;
  b_t          b_o;
  c_t          c_o;
  logic        ld_valid_i = 1'b0;
  logic        ld_ready_o;
  coef_t       ld_data_i = '0;
  logic        commit_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        table_valid_o;
  logic        active_bank_o;
  logic        ld_err_o;

  quadra_coef_table dut (
    .clk           (clk),
    .rst           (rst),
    .rd_valid_i    (rd_valid_i),
    .rd_idx_i      (rd_idx_i),
    .rd_valid_o    (rd_valid_o),
    .a_o           (a_o),
    .b_o           (b_o),
    .c_o           (c_o),
    .ld_valid_i    (ld_valid_i),
    .ld_ready_o    (ld_ready_o),
    .ld_data_i     (ld_data_i),
    .commit_i      (commit_i),
    .abort_i       (abort_i),
    .table_valid_o (table_valid_o),
    .active_bank_o (active_bank_o),
    .ld_err_o      (ld_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    tag;
    coef_t dat;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int      errors = 0;
  int      checks = 0;
  int      cyc = 0;
  int      read_pct = 0;

  // Reference model: the visible table, the table being built, and status flags.
  coef_t   act_m [DEPTH];
  coef_t   shd_m [DEPTH];
  int      beats_m = 0;
  bit      tv_m = 1'b0;
  bit      bank_m = 1'b0;
  bit      err_m = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_status(input string name);
    chk({name, "_table_valid"}, 64'(table_valid_o), 64'(tv_m));
    chk({name, "_active_bank"}, 64'(active_bank_o), 64'(bank_m));
    chk({name, "_ld_err"},      64'(ld_err_o),      64'(err_m));
  endtask

  // One clock of stimulus; optionally issues a read (random or forced index).
  task automatic step(input int fidx = -1);
    int idx;
    rd_valid_i = 1'b0;
    if (!rst && (fidx >= 0 || $urandom_range(99) < read_pct)) begin
      idx = (fidx >= 0) ? fidx : int'($urandom_range(DEPTH - 1));
      rd_valid_i = 1'b1;
      rd_idx_i   = x1_t'(idx);
      sb_q.push_back('{tag: cyc, dat: (tv_m ? act_m[idx] : coef_t'(0))});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_beat(input coef_t d);
    ld_valid_i = 1'b1;
    ld_data_i  = d;
    chk("ld_ready_loading", 64'(ld_ready_o), 64'd1);
    shd_m[beats_m] = d;
    beats_m++;
    step();
    ld_valid_i = 1'b0;
  endtask

  // pat 0 is the arithmetic pattern {i, i+1000, i+50000}; otherwise random words.
  task automatic load(input int n, input int pat, input int gap_pct);
    coef_t d;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        ld_data_i = coef_t'({$urandom, $urandom});
        step();
      end
      if (pat == 0)
        d = make_coef(a_t'(beats_m), b_t'(beats_m + 1000), c_t'(beats_m + 50000));
      else
        d = coef_t'({$urandom, $urandom});
      send_beat(d);
    end
  endtask

  // A complete shadow becomes visible to reads issued two cycles after the commit pulse.
  task automatic do_commit(input string name);
    bit full;
    full = (beats_m == DEPTH);
    if (full) chk({name, "_ready_full"}, 64'(ld_ready_o), 64'd0);
    commit_i = 1'b1;
    if (!full) err_m = 1'b1;
    step();
    commit_i = 1'b0;
    if (full) begin
      step();
      act_m   = shd_m;
      tv_m    = 1'b1;
      bank_m  = ~bank_m;
      beats_m = 0;
    end
    chk_status(name);
    chk({name, "_ready_after"}, 64'(ld_ready_o), 64'd1);
  endtask

  task automatic do_abort(input string name, input bit with_commit);
    abort_i  = 1'b1;
    commit_i = with_commit;
    step();
    abort_i  = 1'b0;
    commit_i = 1'b0;
    beats_m  = 0;
    chk_status(name);
    chk({name, "_ready"}, 64'(ld_ready_o), 64'd1);
  endtask

  // Scoreboard monitor: every valid read must match the oldest outstanding request.
  always @(negedge clk) begin
    rd_exp_t e;
    if (rd_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL rd_unexpected: rd_valid_o high with no read outstanding (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("rd_latency", 64'(cyc), 64'(e.tag + 2));
        chk("rd_data", 64'({a_o, b_o, c_o}), 64'(e.dat));
      end
    end
  end

  initial begin
    // Reset held three cycles.
    step();
    chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    chk("rst_abc", 64'({a_o, b_o, c_o}), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready_o), 64'd0);
    chk_status("rst");
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rel_ld_ready", 64'(ld_ready_o), 64'd1);

    // Full load of the arithmetic pattern with reads of the empty table, then commit.
    read_pct = 50;
    load(DEPTH, 0, 0);
    do_commit("commit1");
    step(5);
    for (int i = 0; i < 20; i++) step();

    // Early commit with reads every cycle, then finish the load across the swap.
    read_pct = 100;
    load(40, 1, 0);
    do_commit("early");
    load(DEPTH - 40, 1, 0);
    do_commit("commit2");
    for (int i = 0; i < 10; i++) step();

    // Abort mid-load with gaps, abort+commit on a full shadow, then reload Q.
    read_pct = 60;
    load(60, 1, 30);
    do_abort("abort_load", 1'b0);
    load(DEPTH, 1, 20);
    do_abort("abort_full", 1'b1);
    load(DEPTH, 1, 25);
    do_commit("commitq");
    read_pct = 0;
    for (int i = 0; i < DEPTH; i++) step(i);

    // Reset during a load with reads in flight, then rebuild from scratch.
    read_pct = 100;
    load(30, 1, 0);
    ld_valid_i = 1'b0;
    rst = 1'b1;
    step();
    sb_q.delete();
    chk("midrst_rd_valid", 64'(rd_valid_o), 64'd0);
    rst     = 1'b0;
    tv_m    = 1'b0;
    bank_m  = 1'b0;
    err_m   = 1'b0;
    beats_m = 0;
    chk_status("midrst");
    for (int i = 0; i < 5; i++) step();
    load(DEPTH, 0, 10);
    do_commit("commit_after_rst");
    for (int i = 0; i < 30; i++) step();

    // Drain outstanding reads.
    read_pct = 0;
    for (int i = 0; i < 4; i++) step();
    chk("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
